// File: rtl/bpr_pkg.sv
// Shared definitions for the 3x3 neighbourhood statistics block:
// FSM states, datapath widths and the tap weight table.
package bpr_pkg;

  typedef enum logic [1:0] {ACCUM, VAR, SQRT, OUT} state_e;

  localparam int PIX_W_DEF = 16;
  localparam int S_W       = 20;
  localparam int Q_W       = 36;
  localparam int ROOT_W    = 16;
  localparam int RAD_W     = 32;
  localparam int N_TAPS    = 9;

  // Two bits per tap, tap 0 in the LSBs; corners 1, edges 3, centre 0.
  localparam logic [2*N_TAPS-1:0] WEIGHT_TBL = {
    2'd1, 2'd3, 2'd1,
    2'd3, 2'd0, 2'd3,
    2'd1, 2'd3, 2'd1
  };

  function automatic logic [1:0] tap_weight(input logic [3:0] idx);
    return (idx < 4'd9) ? WEIGHT_TBL[int'(idx)*2 +: 2] : 2'd0;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Restoring integer square root, one result bit per cycle.
// done_o pulses during the final iteration; root_o is final from the next cycle and holds until the next start.
module isqrt_seq
  import bpr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [RAD_W-1:0]  radicand_i,
  output logic              done_o,
  output logic [ROOT_W-1:0] root_o
);

  localparam int REM_W = ROOT_W + 4;

  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d, rem_t, trial;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy, ge;

  assign busy   = (cnt_q != 5'd0);
  assign done_o = (cnt_q == 5'd1);
  assign root_o = root_q;

  always_comb begin
    rem_t  = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    trial  = {2'b00, root_q, 2'b01};
    ge     = (rem_t >= trial);
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      rad_d  = radicand_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = 5'(ROOT_W);
    end else if (busy) begin
      rad_d  = {rad_q[RAD_W-3:0], 2'b00};
      rem_d  = ge ? (rem_t - trial) : rem_t;
      root_d = {root_q[ROOT_W-2:0], ge};
      cnt_d  = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/neighborhood_stats.sv
// Weighted mean and standard deviation of the 8 neighbours of a 3x3 window,
// streamed in raster order; one window in flight at a time.
module neighborhood_stats
  import bpr_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pixel_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] weighted_mean,
  output logic [31:0] std_dev,
  output logic [31:0] center_pixel,
  output logic        out_valid,
  input  logic        out_ready
);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [Q_W-1:0]    q_q, q_d;
  logic [ROOT_W-1:0] mean_q, mean_d;
  logic [31:0]       ctr_q, ctr_d;

  logic [ROOT_W-1:0] pix, mean_c, root;
  logic [1:0]        w;
  logic [31:0]       sq, e2, msq, variance;
  logic [32:0]       diff;
  logic              sqrt_start, sqrt_done;

  assign pix    = ROOT_W'(pixel_in[PIX_W-1:0]);
  assign w      = tap_weight(idx_q);
  assign sq     = 32'(pix) * 32'(pix);
  assign mean_c = s_q[S_W-1:4];
  assign e2     = q_q[Q_W-1:4];
  assign msq    = 32'(mean_c) * 32'(mean_c);
  // Truncation of S and Q can push E2 just below mean^2; clamp to zero.
  assign diff     = {1'b0, e2} - {1'b0, msq};
  assign variance = diff[32] ? 32'd0 : diff[31:0];

  assign in_ready      = (state_q == ACCUM);
  assign out_valid     = (state_q == OUT);
  assign weighted_mean = 32'(mean_q);
  assign std_dev       = 32'(root);
  assign center_pixel  = ctr_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    s_d        = s_q;
    q_d        = q_q;
    mean_d     = mean_q;
    ctr_d      = ctr_q;
    sqrt_start = 1'b0;
    case (state_q)
      ACCUM: if (in_valid) begin
        s_d   = s_q + S_W'(w) * S_W'(pix);
        q_d   = q_q + Q_W'(w) * Q_W'(sq);
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd4) ctr_d = pixel_in;
        if (idx_q == 4'd8) state_d = VAR;
      end
      VAR: begin
        mean_d     = mean_c;
        sqrt_start = 1'b1;
        state_d    = SQRT;
      end
      SQRT: if (sqrt_done) state_d = OUT;
      OUT: if (out_ready) begin
        state_d = ACCUM;
        idx_d   = '0;
        s_d     = '0;
        q_d     = '0;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      s_q     <= '0;
      q_q     <= '0;
      mean_q  <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      q_q     <= q_d;
      mean_q  <= mean_d;
      ctr_q   <= ctr_d;
    end
  end

  isqrt_seq u_sqrt (
    .clk        (clk),
    .rst_n      (reset),
    .start_i    (sqrt_start),
    .radicand_i (variance),
    .done_o     (sqrt_done),
    .root_o     (root)
  );

endmodule

// File: tb/tb_neighborhood_stats.sv
// Directed bench for neighborhood_stats: hand-computed windows, latency,
// backpressure and reset-abort cases.
module tb_neighborhood_stats;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pixel_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] weighted_mean, std_dev, center_pixel;
  logic        out_valid;
  logic        out_ready;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int t8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neighborhood_stats #(.PIX_W(16)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .pixel_in      (pixel_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .weighted_mean (weighted_mean),
    .std_dev       (std_dev),
    .center_pixel  (center_pixel),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
  endtask

  task automatic send(input logic [31:0] p, output int tacc);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    pixel_in = p;
    in_valid = 1'b1;
    tacc     = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_window(input logic [31:0] pc, input logic [31:0] pe, input logic [31:0] pm);
    int ta;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) send(pm, ta);
      else if (i % 2 == 1) send(pe, ta);
      else send(pc, ta);
    end
    t8 = ta;
  endtask

  task automatic wait_out(input string tag);
    int w = 0;
    @(negedge clk);
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_lat"}, cyc - t8, 32'd18);
  endtask

  task automatic take_out(input string tag, input logic [31:0] em, input logic [31:0] es,
                          input logic [31:0] ec);
    chk({tag, "_mean"}, weighted_mean, em);
    chk({tag, "_std"}, std_dev, es);
    chk({tag, "_ctr"}, center_pixel, ec);
    chk({tag, "_rdy_in_out"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int ta;
    rst_n     = 1'b0;
    pixel_in  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_mean", weighted_mean, 32'd0);
    chk("rst_std", std_dev, 32'd0);
    chk("rst_ctr", center_pixel, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    // Flat window
    send_window(32'd100, 32'd100, 32'd100);
    wait_out("flat100");
    take_out("flat100", 32'd100, 32'd0, 32'd100);

    // Variance 48; out_ready held high while accumulating must not matter
    out_ready = 1'b1;
    send_window(32'd0, 32'd16, 32'd500);
    wait_out("var48");
    take_out("var48", 32'd12, 32'd6, 32'd500);

    // Full-scale pixels
    send_window(32'd65535, 32'd65535, 32'd65535);
    wait_out("max");
    take_out("max", 32'd65535, 32'd0, 32'd65535);

    // Upper sample bits ignored, centre passed through raw
    send_window(32'h0001_0005, 32'h0001_0005, 32'h0001_0005);
    wait_out("hibits");
    take_out("hibits", 32'd5, 32'd0, 32'h0001_0005);

    // Backpressure: S=280 mean 17, E2=325, var 36, std 6
    send_window(32'd10, 32'd20, 32'd3);
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      pixel_in = 32'd999;
      in_valid = 1'b1;
      chk("bp_hold_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_mean", weighted_mean, 32'd17);
      chk("bp_hold_std", std_dev, 32'd6);
      chk("bp_hold_ctr", center_pixel, 32'd3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take_out("bp", 32'd17, 32'd6, 32'd3);

    // Reset mid-SQRT, then reset mid-window, then a clean window of 7s
    send_window(32'd50, 32'd90, 32'd50);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ov", {31'd0, out_valid}, 32'd0);
    chk("abort_mean", weighted_mean, 32'd0);
    chk("abort_std", std_dev, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(32'd1000, ta);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_window(32'd7, 32'd7, 32'd7);
    wait_out("seven");
    take_out("seven", 32'd7, 32'd0, 32'd7);
    for (int i = 0; i < 25; i++) begin
      chk("idle_ov", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neighborhood_stats.md
NEIGHBORHOOD_STATS -- requirements
Module: neighborhood_stats

Interface
REQ-001 SHALL have parameter PIX_W, default 16: number of valid pixel bits, taken from the LSBs of each 32-bit sample.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pixel_in, input, 32 bits: one sample of the 3x3 window, in raster order.
REQ-005 SHALL have port in_valid, input, 1 bit: pixel_in is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 SHALL have port weighted_mean, output, 32 bits: weighted mean of the 8 neighbours, zero-extended.
REQ-008 SHALL have port std_dev, output, 32 bits: weighted standard deviation of the 8 neighbours, zero-extended.
REQ-009 SHALL have port center_pixel, output, 32 bits: the window centre sample (index 4) as received.
REQ-010 SHALL have port out_valid, output, 1 bit: the result triple is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the result.

Function
REQ-012 SHALL accept a sample when in_valid and in_ready are both 1 in the same cycle.
REQ-013 SHALL number accepted samples 0..8 with a 4-bit index counter; index 4 is the centre sample.
REQ-014 SHALL weight samples as follows: corners (0, 2, 6, 8) weight 1; edges (1, 3, 5, 7) weight 3; centre weight 0. The weights total 16.
REQ-015 SHALL use only the low PIX_W bits of each sample as an unsigned value and ignore the upper bits.
REQ-016 SHALL accumulate the weighted sum S in 20 bits and the weighted sum of squares Q in 36 bits, with no overflow possible.
REQ-017 SHALL compute mean = S>>4 and E2 = Q>>4, both truncating.
REQ-018 SHALL compute variance = E2 - mean^2, clamped to 0 if the result is negative; the variance fits in 32 bits.
REQ-019 SHALL compute std_dev as floor(sqrt(variance)), a 16-bit result, using a restoring square root that resolves one bit per cycle over 16 cycles.
REQ-020 SHALL implement the FSM states ACCUM, VAR, SQRT and OUT.
REQ-021 SHALL implement these transitions:
- ACCUM -> VAR on acceptance of sample 8
- VAR -> SQRT after 1 cycle
- SQRT -> OUT after 16 cycles
- OUT -> ACCUM on out_valid and out_ready both 1
REQ-022 SHALL drive in_ready = 1 only in ACCUM and out_valid = 1 only in OUT.
REQ-023 SHALL meet this latency: if sample 8 is accepted at cycle T, out_valid rises at T+18.
REQ-024 SHALL hold weighted_mean, std_dev and center_pixel stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on the output handshake, clear S, Q and the index so that in_ready=1 in the next cycle; there is no overlap between windows.
REQ-026 SHALL ignore in_valid outside ACCUM, and SHALL ignore out_ready outside OUT.

Reset
REQ-027 SHALL, while reset=0 asynchronously, force:
- state = ACCUM, index = 0
- S = 0, Q = 0
- weighted_mean = 0, std_dev = 0, center_pixel = 0
- out_valid = 0
REQ-028 SHALL drive in_ready = 1 in the first cycle after reset deasserts.
REQ-029 SHALL, if reset is asserted mid-window or mid-SQRT, discard the partial result and emit no output for that window.

Structure
REQ-030 SHALL take from the shared package bpr_pkg:
- the state enum
- the weight table
- the widths for PIX_W, S (20 bits), Q (36 bits) and the square-root result (16 bits)
REQ-031 SHALL place the iterative square root in the sub-module isqrt_seq (start/done handshake, 32-bit radicand, 16-bit root).
REQ-032 SHALL be directly consumable by the downstream replacement stage: weighted_mean, std_dev and center_pixel are delivered aligned.

Verification
REQ-033 SHALL cover: all nine samples = 100 -> mean 100, std_dev 0, center_pixel 100, with out_valid at T+18.
REQ-034 SHALL cover: corners 0, edges 16, centre 500 -> mean 12, std_dev 6 (variance 48), center_pixel 500.
REQ-035 SHALL cover: all samples 65535 -> mean 65535, std_dev 0; the negative-variance clamp is not triggered and there is no overflow.
REQ-036 SHALL cover: sample 0x0001_0005 at every position -> it is treated as 5, giving mean 5; center_pixel = 0x0001_0005.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles in OUT -> outputs stable, in_ready stays 0; after the handshake, in_ready = 1 in the next cycle.
REQ-038 SHALL cover: reset asserted during SQRT, then a new window of all 7s -> a single output with mean 7 and std_dev 0, and no stale output.
